// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    localparam addr_t RESET_VECTOR_DEFAULT = 32'h8000_0000;
    localparam inst_t EBREAK_INST          = 32'h0010_0073;

    typedef struct packed {
        inst_t bits;
        addr_t pc;
    } fq_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Circular buffer with synchronous flush; push and pop may coincide when full.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the count gates whether the head is meaningful.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers in-order responses, handles redirects.
// Optional ebreak halt enabled by defining IFU_EBREAK_HALT_EN.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int    DEPTH        = 4,
    parameter addr_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst_bits,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high; valid never depends on ready, and redirect overrides every transfer.

    logic          run_q;
    addr_t         fetch_pc_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic          halted_q;
    logic          fire;
    logic          keep_resp;
    logic          pop;
    addr_t         tag_head;
    fq_entry_t     head;
    logic [CW-1:0] tag_count_unused;
    logic [1:0]    redirect_lsb_unused;

    assign occupancy      = {1'b0, count} + {1'b0, inflight_q};
    assign imem_req_valid = run_q && (occupancy < DEPTH_L) && !redirect_valid && !halted_q;
    assign imem_req_addr  = fetch_pc_q;
    assign fire           = imem_req_valid && imem_req_ready;
    assign keep_resp      = imem_resp_valid && (drop_q == '0) && !redirect_valid;
    assign pop            = inst_valid && inst_ready && !redirect_valid;
    assign redirect_lsb_unused = redirect_pc[1:0];

    // run_q holds off requests until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_VECTOR;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            run_q <= 1'b1;
            if (redirect_valid) begin
                fetch_pc_q <= {redirect_pc[31:2], 2'b00};
                inflight_q <= inflight_q - CW'(imem_resp_valid);
                drop_q     <= inflight_q - CW'(imem_resp_valid);
            end else begin
                if (fire) fetch_pc_q <= fetch_pc_q + 32'd4;
                inflight_q <= inflight_q + CW'(fire) - CW'(imem_resp_valid);
                if (imem_resp_valid && drop_q != '0) drop_q <= drop_q - CW'(1);
            end
        end
    end

    // Tags cover only responses that will be kept; stale ones are counted by drop_q.
    ifu_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fire),
        .push_data (fetch_pc_q),
        .pop       (keep_resp),
        .head      (tag_head),
        .count     (tag_count_unused)
    );

    ifu_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (keep_resp),
        .push_data ({imem_resp_data, tag_head}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign inst_valid = (count != '0);
    assign inst_bits  = inst_valid ? head.bits : '0;
    assign inst_pc    = inst_valid ? head.pc   : '0;

`ifdef IFU_EBREAK_HALT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else if (pop && head.bits == EBREAK_INST) begin
            halted_q <= 1'b1;
        end
    end
`else
    assign halted_q = 1'b0;
`endif

    assign halted = halted_q;

endmodule

// File: doc/ifu_fetch_queue.md
IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4: queue entries and maximum in-flight plus buffered fetches; power of two, 2..16.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h8000_0000: first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request this cycle.
REQ-008 SHALL have port imem_resp_valid  input  1  in-order response, one per accepted request, latency >= 1.
REQ-009 SHALL have port imem_resp_data  input  32  fetched instruction word.
REQ-010 SHALL have port inst_valid  output  1  instruction offered to the core.
REQ-011 SHALL have port inst_bits  output  32  instruction word at queue head.
REQ-012 SHALL have port inst_pc  output  32  address of inst_bits.
REQ-013 SHALL have port inst_ready  input  1  core consumes head when inst_valid is high.
REQ-014 SHALL have port redirect_valid  input  1  core-requested PC change (branch, jump, trap).
REQ-015 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored.
REQ-016 SHALL have port halted  output  1  fetch stopped by ebreak (zero when the halt feature is compiled out).

Function
REQ-017 SHALL track fetch_pc, in-flight count (inflight), queue occupancy (count) and drop count (drop).
REQ-018 SHALL assert imem_req_valid only when count + inflight < DEPTH, no redirect this cycle, and not halted.
REQ-019 SHALL advance fetch_pc by 4 and increment inflight on each imem_req_valid && imem_req_ready.
REQ-020 SHALL, on imem_resp_valid with drop == 0, push {data, pc} into the queue; pc comes from a matching PC tag queue of the same depth.
REQ-021 SHALL, on imem_resp_valid with drop > 0, discard the response and decrement drop.
REQ-022 SHALL pop the head when inst_valid && inst_ready; inst_valid = (count != 0).
REQ-023 SHALL, on redirect_valid, flush the queue the same cycle, set fetch_pc = {redirect_pc[31:2],2'b00} and set drop = inflight minus any response arriving that cycle; inst_valid is 0 in the next cycle.
REQ-024 SHALL give redirect priority over a simultaneous pop, push or request; no request is issued in the redirect cycle.
REQ-025 SHALL allow push and pop in the same cycle when full; count is unchanged.
REQ-026 SHALL wrap queue pointers modulo DEPTH; fetch_pc wraps modulo 2^32.
REQ-027 SHALL have minimum latency from request acceptance to inst_valid of memory latency + 1 cycle (registered queue output).

Reset
REQ-028 SHALL, while rst is low, set fetch_pc = RESET_VECTOR, count = inflight = drop = 0, imem_req_valid = 0, inst_valid = 0, halted = 0, inst_bits = 0 and inst_pc = 0.
REQ-029 SHALL discard all responses while rst is low; responses to requests issued before reset are not tracked; system integration guarantees memory quiescence across reset.

Configuration
REQ-030 SHALL, with IFU_EBREAK_HALT_EN defined, set halted the cycle after an instruction equal to 32'h0010_0073 is popped, stop issuing requests, keep remaining queue entries, and clear halted only on reset; redirect does not clear it.
REQ-031 SHALL, without IFU_EBREAK_HALT_EN, treat ebreak as an ordinary word and tie halted to 0.

Structure
REQ-032 SHALL place RESET_VECTOR default, EBREAK_INST (32'h0010_0073) and the 32-bit address/instruction typedefs in shared package ifu_pkg.
REQ-033 SHALL implement the data/PC storage as sub-module ifu_fifo (parameterised width and depth, flush input); counters and the request logic stay in ifu_fetch_queue.

Verification
REQ-034 SHALL cover reset then 1-cycle memory, inst_ready=1 -> inst_pc sequence 0x80000000, 0x80000004, ... with one instruction per cycle in steady state.
REQ-035 SHALL cover inst_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid held 0 until a pop.
REQ-036 SHALL cover redirect to 0x80001002 with 3 requests in flight -> 3 responses dropped, next inst_pc = 0x80001000.
REQ-037 SHALL cover redirect coincident with pop and response -> queue empty next cycle, no request in redirect cycle, drop = inflight - 1.
REQ-038 SHALL cover, with IFU_EBREAK_HALT_EN, ebreak popped at 0x80000008 -> halted = 1 the next cycle, no further requests; without the macro -> fetch continues to 0x8000000C.
REQ-039 SHALL cover asserting rst mid-stream with a full queue -> inst_valid = 0 immediately, first request after release at 0x80000000.
